// File: rtl/utils_pkg.sv
// Shared helpers for the read-side word packer: lane-count type and keep-mask builder.
package utils_pkg;

  localparam int unsigned MaxLanes = 32;
  localparam int unsigned LaneCntW = $clog2(MaxLanes + 1);

  typedef logic [LaneCntW-1:0] lane_cnt_t;

  // Thermometer mask with the low 'count' bits set, i.e. (1 << count) - 1.
  function automatic logic [MaxLanes-1:0] mask_from_count(input lane_cnt_t count);
    logic [MaxLanes-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MaxLanes; i++) begin
      if (i < 32'(count)) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Valid/ready output register: holds the packed word and keep mask until accepted.
module stream_out_reg #(
  parameter int unsigned DataW = 32,
  parameter int unsigned KeepW = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [DataW-1:0] data_i,
  input  logic [KeepW-1:0] keep_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [DataW-1:0] data_o,
  output logic [KeepW-1:0] keep_o,
  output logic             out_free_c
);

  // Register may take a new word when empty or when the current word leaves this cycle.
  assign out_free_c = !valid_o || ready_i;

  // Load on transfer; otherwise drop valid once the downstream accepts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      keep_o  <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
      keep_o  <= keep_i;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Read-side FIFO consumer: packs Lanes consecutive entries (lane 0 first) into one
// wide word and streams it out over valid/ready.
// Optional build macro PACKER_FLUSH_EN: flush a partial word after TimeoutCycles idle cycles.
module fifo_word_packer
  import utils_pkg::*;
#(
  parameter int unsigned Width         = 8,
  parameter int unsigned Lanes         = 4,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  output logic                     fifo_read_req_o,
  input  logic                     fifo_read_valid_i,
  input  logic [Width-1:0]         fifo_data_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [Width*Lanes-1:0]   data_o,
  output logic [Lanes-1:0]         keep_o
);

  localparam int unsigned CntW  = $clog2(Lanes + 1);
  localparam int unsigned WordW = Width * Lanes;

  logic [CntW-1:0]               count_q, count_d;
  logic                          pending_q;
  logic [Lanes-1:0][Width-1:0]   acc_q, acc_d;
  logic                          out_free;
  logic                          full;
  logic                          room;
  logic                          fire;
  logic                          xfer;
  logic                          flush;
  logic [Lanes-1:0]              keep_xfer;

  assign full = (count_q == CntW'(Lanes));

  // Lanes already captured plus the one in flight must leave room for another pop.
  assign room = (({1'b0, count_q} + (CntW + 1)'(pending_q)) < (CntW + 1)'(Lanes));

`ifdef PACKER_FLUSH_EN
  localparam int unsigned IdleW = $clog2(TimeoutCycles + 1);

  logic [IdleW-1:0] idle_q;
  logic             partial;

  assign partial = (count_q != '0) && !full;

  // Flush a stranded partial word once the idle budget is used up and the output is free.
  assign flush = (idle_q == IdleW'(TimeoutCycles)) && out_free && partial && !pending_q;

  // Flushed words only carry the lanes that were actually filled.
  assign keep_xfer = flush ? Lanes'(mask_from_count(lane_cnt_t'(count_q))) : '1;

  // Idle counter: runs while a partial word waits with nothing in flight, saturates at the timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_q <= '0;
    end else if (fire || xfer) begin
      idle_q <= '0;
    end else if (partial && !pending_q && (idle_q != IdleW'(TimeoutCycles))) begin
      idle_q <= idle_q + IdleW'(1);
    end
  end
`else
  assign flush     = 1'b0;
  assign keep_xfer = '1;
`endif

  // Pop/transfer control; the pop request never looks at fifo_read_valid_i.
  always_comb begin
    fifo_read_req_o = 1'b0;
    xfer            = 1'b0;
    if (full && out_free) xfer = 1'b1;
    if (flush)            xfer = 1'b1;
    if ((room || (full && out_free)) && !flush) fifo_read_req_o = 1'b1;
    fire = fifo_read_req_o && fifo_read_valid_i;
  end

  // Accumulator next state: clear on transfer, otherwise capture the in-flight entry.
  always_comb begin
    count_d = count_q;
    acc_d   = acc_q;
    if (xfer) begin
      count_d = '0;
      acc_d   = '0;
    end else if (pending_q) begin
      for (int unsigned i = 0; i < Lanes; i++) begin
        if (count_q == CntW'(i)) acc_d[i] = fifo_data_i;
      end
      count_d = count_q + CntW'(1);
    end
  end

  // Packing state registers; an in-flight pop is dropped on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q   <= '0;
      pending_q <= 1'b0;
      acc_q     <= '0;
    end else begin
      count_q   <= count_d;
      pending_q <= fire;
      acc_q     <= acc_d;
    end
  end

  stream_out_reg #(
    .DataW (WordW),
    .KeepW (Lanes)
  ) u_out (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (xfer),
    .data_i     (acc_q),
    .keep_i     (keep_xfer),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .keep_o     (keep_o),
    .out_free_c (out_free)
  );

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed + random bench for fifo_word_packer with a FIFO model and a word scoreboard.
module tb_fifo_word_packer;

  localparam int unsigned W = 8;
  localparam int unsigned L = 4;
  localparam int unsigned T = 16;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           fifo_read_req_o;
  logic           fifo_read_valid_i;
  logic [W-1:0]   fifo_data_i;
  logic           valid_o;
  logic           ready_i;
  logic [W*L-1:0] data_o;
  logic [L-1:0]   keep_o;

  always #5 clk_i = ~clk_i;

  fifo_word_packer #(
    .Width         (W),
    .Lanes         (L),
    .TimeoutCycles (T)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .fifo_read_req_o   (fifo_read_req_o),
    .fifo_read_valid_i (fifo_read_valid_i),
    .fifo_data_i       (fifo_data_i),
    .valid_o           (valid_o),
    .ready_i           (ready_i),
    .data_o            (data_o),
    .keep_o            (keep_o)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0]     fifo_q[$];
  logic [W*L+L-1:0] exp_q[$];

  int             vmode     = 0;   // 0: valid when non-empty, 1: toggling, 2: random
  logic           vtog      = 1'b0;
  logic           ready_fix = 1'b1;
  logic           rmode     = 1'b0;
  logic           fire_prev = 1'b0;
  int             cyc           = 0;
  int             last_fire_cyc = 0;
  int             rise_cyc      = 0;
  int             vld_samples   = 0;
  int             acc_cnt       = 0;
  logic           prev_stall = 1'b0;
  logic           prev_valid = 1'b0;
  logic [W*L-1:0] prev_data  = '0;
  logic [L-1:0]   prev_keep  = '0;
  logic           gate;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [W*L-1:0] w, input logic [L-1:0] k);
    for (int i = 0; i < int'(L); i++) begin
      if (k[i]) fifo_q.push_back(w[i*W +: W]);
    end
    exp_q.push_back({k, w});
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_i);
    #2;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
      @(negedge clk_i);
      #2;
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // FIFO model, input driver and output monitor; inputs change at negedge, sampled 1ns later.
  initial begin
    fifo_read_valid_i = 1'b0;
    fifo_data_i       = '0;
    ready_i           = 1'b1;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (fire_prev && rst_ni) fifo_data_i = fifo_q.pop_front();
      if (vmode == 1) vtog = !vtog;
      gate = (vmode == 0) ? 1'b1 : (vmode == 1) ? vtog : ($urandom_range(0, 3) != 0);
      fifo_read_valid_i = gate && (fifo_q.size() > 0);
      ready_i = rmode ? ($urandom_range(0, 3) != 0) : ready_fix;
      #1;
      fire_prev = rst_ni && fifo_read_req_o && fifo_read_valid_i;
      if (fire_prev) last_fire_cyc = cyc;
      if (!rst_ni) begin
        prev_stall = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 64'(valid_o), 64'd1);
          chk("hold_data", 64'(data_o), 64'(prev_data));
          chk("hold_keep", 64'(keep_o), 64'(prev_keep));
        end
        if (valid_o && !prev_valid) rise_cyc = cyc;
        if (valid_o) vld_samples++;
        if (valid_o && ready_i) begin
          checks++;
          assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL sb_unexpected observed=0x%0h expected=none", data_o);
          end
          if (exp_q.size() != 0) begin
            logic [W*L+L-1:0] e;
            e = exp_q.pop_front();
            chk("sb_data", 64'(data_o), 64'(e[W*L-1:0]));
            chk("sb_keep", 64'(keep_o), 64'(e[W*L +: L]));
          end
          acc_cnt++;
        end
        prev_stall = valid_o && !ready_i;
        prev_data  = data_o;
        prev_keep  = keep_o;
        prev_valid = valid_o;
      end
    end
  end

  initial begin
    int base;
    rst_ni = 1'b0;
    wait_cycles(3);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_keep", 64'(keep_o), 64'd0);
    rst_ni = 1'b1;
    wait_cycles(1);
    chk("rst_req", 64'(fifo_read_req_o), 64'd1);

    // 1: back-to-back pops, ready high
    vld_samples = 0;
    base = acc_cnt;
    push_word(32'h44332211, 4'hF);
    wait_drain("t1_drain", 50);
    wait_cycles(5);
    chk("t1_words", 64'(acc_cnt - base), 64'd1);
    chk("t1_valid_cycles", 64'(vld_samples), 64'd1);
    // last fire sampled before edge N; valid first visible after edge N+2
    chk("t1_latency", 64'(rise_cyc - last_fire_cyc), 64'd3);

    // 2: downstream stalled with 8 entries queued
    ready_fix = 1'b0;
    base = acc_cnt;
    push_word(32'h44332211, 4'hF);
    push_word(32'h88776655, 4'hF);
    wait_cycles(30);
    chk("t2_valid", 64'(valid_o), 64'd1);
    chk("t2_data", 64'(data_o), 64'h44332211);
    chk("t2_keep", 64'(keep_o), 64'hF);
    chk("t2_req_low", 64'(fifo_read_req_o), 64'd0);
    chk("t2_fifo_empty", 64'(fifo_q.size()), 64'd0);
    ready_fix = 1'b1;
    wait_drain("t2_drain", 50);
    wait_cycles(3);
    chk("t2_words", 64'(acc_cnt - base), 64'd2);
    chk("t2_valid_low", 64'(valid_o), 64'd0);

    // 3: fifo valid toggling
    vmode = 1;
    base = acc_cnt;
    push_word(32'h44332211, 4'hF);
    wait_drain("t3_drain", 80);
    wait_cycles(3);
    chk("t3_words", 64'(acc_cnt - base), 64'd1);
    vmode = 0;

    // 4: reset mid-stream with a held word and two captured lanes
    ready_fix = 1'b0;
    push_word(32'h44332211, 4'hF);
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'h02);
    wait_cycles(20);
    chk("t4_valid_before", 64'(valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("t4_rst_valid", 64'(valid_o), 64'd0);
    chk("t4_rst_data", 64'(data_o), 64'd0);
    chk("t4_rst_keep", 64'(keep_o), 64'd0);
    exp_q.delete();
    @(negedge clk_i);
    #2;
    rst_ni = 1'b1;
    ready_fix = 1'b1;
    base = acc_cnt;
    push_word(32'hA4A3A2A1, 4'hF);
    wait_drain("t4_drain", 50);
    wait_cycles(3);
    chk("t4_words", 64'(acc_cnt - base), 64'd1);

    // 5: partial word then FIFO empty
`ifdef PACKER_FLUSH_EN
    base = acc_cnt;
    push_word(32'h0000BBAA, 4'b0011);
    wait_drain("t5_flush_drain", 60);
    wait_cycles(3);
    chk("t5_words", 64'(acc_cnt - base), 64'd1);
    // fire before edge N, capture N+1, 16 idle edges N+2..N+17, flush at N+18
    chk("t5_flush_delay", 64'(rise_cyc - last_fire_cyc), 64'd19);
`else
    vld_samples = 0;
    fifo_q.push_back(8'hAA);
    fifo_q.push_back(8'hBB);
    exp_q.push_back({4'hF, 32'hDDCCBBAA});
    wait_cycles(100);
    chk("t5_no_valid", 64'(vld_samples), 64'd0);
    fifo_q.push_back(8'hCC);
    fifo_q.push_back(8'hDD);
    wait_drain("t5_complete_drain", 50);
`endif

    // 6: random valid/ready, 10k entries
    vmode = 2;
    rmode = 1'b1;
    base = acc_cnt;
    for (int i = 0; i < 2500; i++) push_word(32'($urandom()), 4'hF);
    wait_drain("t6_drain", 60000);
    rmode = 1'b0;
    ready_fix = 1'b1;
    vmode = 0;
    wait_cycles(3);
    chk("t6_words", 64'(acc_cnt - base), 64'd2500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
